out_bank_hs: RTL and testbench

Parametrised output register bank, successor to the fixed 16-channel 8-bit output block. Host writes one channel per cycle by address, or all channels at once by broadcast. Each channel presents {valid, data} to its consumer. A per-channel ack handshake, sticky overrun flags and an optional valid auto-expire timer are added. Sits between the byte-wide core write path and the external output ports.

---
 rtl/out_bank_hs_if.sv | 27 ++
 rtl/out_bank_hs.sv | 108 ++++++++++
 tb/tb_out_bank_hs.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/out_bank_hs_if.sv
// Host write port, consumer acks and per-channel outputs of the out_bank_hs register bank.
// Each channel offers valid with its data; the consumer takes it by raising ack while valid.
interface out_bank_hs_if #(
    parameter int NCH = 16,
    parameter int AW  = 4,
    parameter int DW  = 8
);
    logic                   enable;
    logic [AW-1:0]          addr;
    logic                   bcast;
    logic [DW-1:0]          in_data;
    logic [NCH-1:0]         ack;
    logic                   clr_overrun;
    logic [NCH*(DW+1)-1:0]  out_bus;
    logic [NCH-1:0]         overrun;
    logic                   addr_err;

    modport master (
        output enable, addr, bcast, in_data, ack, clr_overrun,
        input  out_bus, overrun, addr_err
    );

    modport slave (
        input  enable, addr, bcast, in_data, ack, clr_overrun,
        output out_bus, overrun, addr_err
    );
endinterface

// File: rtl/out_bank_hs.sv
// Parametrised output register bank: addressed or broadcast writes, per-channel ack
// handshake, sticky overrun flags and an optional auto-expire timer on valid.
module out_bank_hs #(
    parameter int NCH      = 16,
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int HOLD_CYC = 0
) (
    input  logic          clk,
    input  logic          reset,
    out_bank_hs_if.slave  bus
);
    logic [DW-1:0]  data_q [NCH];
    logic [NCH-1:0] valid_q;
    logic [NCH-1:0] overrun_q;
    logic           addr_err_q;

    logic [NCH-1:0] wr;
    logic [NCH-1:0] acked;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] ovr_set;
    logic [31:0]    addr_ext;
    logic           addr_bad;

    assign addr_ext = 32'(bus.addr);
    assign addr_bad = (addr_ext >= 32'(NCH));

    always_comb begin
        wr = '0;
        if (bus.enable) begin
            if (bus.bcast) begin
                wr = '1;
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (addr_ext == 32'(c)) wr[c] = 1'b1;
                end
            end
        end
    end

    // An ack on the write edge consumes the old value, so only an unacked rewrite overruns.
    assign acked   = bus.ack & valid_q;
    assign ovr_set = wr & valid_q & ~bus.ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) data_q[c] <= '0;
            valid_q    <= '0;
            overrun_q  <= '0;
            addr_err_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr[c]) begin
                    data_q[c]  <= bus.in_data;
                    valid_q[c] <= 1'b1;
                end else if (acked[c] || expire[c]) begin
                    valid_q[c] <= 1'b0;
                end
            end
            overrun_q  <= (bus.clr_overrun ? '0 : overrun_q) | ovr_set;
            addr_err_q <= bus.enable && !bus.bcast && addr_bad;
        end
    end

    generate
        if (HOLD_CYC > 0) begin : g_timer
            localparam int TW = $clog2(HOLD_CYC + 1);
            logic [TW-1:0] tmr_q [NCH];

            always_ff @(posedge clk) begin
                for (int c = 0; c < NCH; c++) begin
                    if (reset) begin
                        tmr_q[c] <= '0;
                    end else if (wr[c]) begin
                        tmr_q[c] <= TW'(HOLD_CYC);
                    end else if (acked[c]) begin
                        tmr_q[c] <= '0;
                    end else if (valid_q[c] && (tmr_q[c] != '0)) begin
                        tmr_q[c] <= tmr_q[c] - TW'(1);
                    end
                end
            end

            // valid drops on the same edge the counter steps from 1 to 0
            always_comb begin
                expire = '0;
                for (int c = 0; c < NCH; c++) begin
                    expire[c] = valid_q[c] && (tmr_q[c] == TW'(1));
                end
            end
        end else begin : g_no_timer
            assign expire = '0;
        end
    endgenerate

    logic [NCH*(DW+1)-1:0] out_bus_w;

    always_comb begin
        out_bus_w = '0;
        for (int c = 0; c < NCH; c++) begin
            out_bus_w[c*(DW+1) +: DW+1] = {valid_q[c], data_q[c]};
        end
    end

    assign bus.out_bus  = out_bus_w;
    assign bus.overrun  = overrun_q;
    assign bus.addr_err = addr_err_q;
endmodule

// File: tb/tb_out_bank_hs.sv
// Directed bench for out_bank_hs: a vector table on a 16-channel bank with 5-bit address,
// plus hand sequences on a HOLD_CYC=3 instance for the expire timer.
module tb_out_bank_hs;
    localparam int NCH = 16;
    localparam int DW  = 8;
    localparam int BW  = NCH * (DW + 1);

    logic clk;
    logic reset;

    out_bank_hs_if #(.NCH(NCH), .AW(5), .DW(DW)) bus_a ();
    out_bank_hs_if #(.NCH(NCH), .AW(4), .DW(DW)) bus_t ();

    out_bank_hs #(.NCH(NCH), .AW(5), .DW(DW), .HOLD_CYC(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    out_bank_hs #(.NCH(NCH), .AW(4), .DW(DW), .HOLD_CYC(3)) u_tmr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_t.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        bc;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic [15:0] ack;
        logic        clr;
        int          ch;
        logic [8:0]  exp_ch;
        logic [15:0] exp_ovr;
        logic        exp_err;
        logic        full;
        logic [BW-1:0] exp_bus;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [BW-1:0] place(input int c, input logic [8:0] v);
        logic [BW-1:0] r;
        r = '0;
        r[c*9 +: 9] = v;
        return r;
    endfunction

    function automatic logic [8:0] get_ch(input logic [BW-1:0] b, input int c);
        return b[c*9 +: 9];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_a(input logic en, input logic bc, input logic [4:0] a, input logic [7:0] d,
                           input logic [15:0] ak, input logic clr);
        bus_a.enable = en;  bus_a.bcast = bc;  bus_a.addr = a;
        bus_a.in_data = d;  bus_a.ack = ak;    bus_a.clr_overrun = clr;
    endtask

    task automatic drive_t(input logic en, input logic [3:0] a, input logic [7:0] d, input logic [15:0] ak);
        bus_t.enable = en;  bus_t.bcast = 1'b0;  bus_t.addr = a;
        bus_t.in_data = d;  bus_t.ack = ak;      bus_t.clr_overrun = 1'b0;
    endtask

    // one timer-instance cycle, with the expected channel value queued then checked
    task automatic t_step(input string name, input logic en, input logic [3:0] a, input logic [7:0] d,
                          input logic [15:0] ak, input int ch, input logic [8:0] exp);
        logic [8:0] e;
        drive_t(en, a, d, ak);
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        check(name, BW'(get_ch(bus_t.out_bus, ch)), BW'(e));
    endtask

    function automatic void add(input string name, input logic rst, input logic en, input logic bc,
                                input logic [4:0] a, input logic [7:0] d, input logic [15:0] ak,
                                input logic clr, input int ch, input logic [8:0] ech,
                                input logic [15:0] eovr, input logic eerr,
                                input logic full, input logic [BW-1:0] ebus);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.bc = bc; v.addr = a; v.data = d;
        v.ack = ak; v.clr = clr; v.ch = ch; v.exp_ch = ech; v.exp_ovr = eovr;
        v.exp_err = eerr; v.full = full; v.exp_bus = ebus;
        vecs.push_back(v);
    endfunction

    logic [BW-1:0] all_5a;

    initial begin
        all_5a = '0;
        for (int c = 0; c < NCH; c++) all_5a[c*9 +: 9] = 9'h15A;

        // name  rst en bc addr data ack clr ch exp_ch exp_ovr err full bus
        add("ack3",        0,0,0,5'd0, 8'h00,16'h0008,0, 3,9'h0C0,16'h0000,0, 0,'0);
        add("ack3_again",  0,0,0,5'd0, 8'h00,16'h0008,0, 3,9'h0C0,16'h0000,0, 0,'0);
        add("wr1_04",      0,1,0,5'd1, 8'h04,16'h0000,0, 1,9'h104,16'h0000,0, 0,'0);
        add("wr1_aa_ovr",  0,1,0,5'd1, 8'hAA,16'h0000,0, 1,9'h1AA,16'h0002,0, 0,'0);
        add("clr_ovr",     0,0,0,5'd0, 8'h00,16'h0000,1, 1,9'h1AA,16'h0000,0, 0,'0);
        add("wr2_11",      0,1,0,5'd2, 8'h11,16'h0000,0, 2,9'h111,16'h0000,0, 0,'0);
        add("wr2_22_ack",  0,1,0,5'd2, 8'h22,16'h0004,0, 2,9'h122,16'h0000,0, 0,'0);
        add("en0_ignored", 0,0,1,5'd2, 8'hFF,16'h0000,0, 2,9'h122,16'h0000,0, 0,'0);
        add("bad_addr20",  0,1,0,5'd20,8'h77,16'h0000,0, 2,9'h122,16'h0000,1, 1,
            place(1,9'h1AA) | place(2,9'h122) | place(3,9'h0C0));
        add("err_pulse",   0,0,0,5'd0, 8'h00,16'h0000,0, 2,9'h122,16'h0000,0, 0,'0);
        add("ovr_set_clr", 0,1,0,5'd1, 8'h55,16'h0000,1, 1,9'h155,16'h0002,0, 0,'0);
        add("ack1_clr",    0,0,0,5'd0, 8'h00,16'h0002,1, 1,9'h055,16'h0000,0, 0,'0);
        add("bcast_5a",    0,1,1,5'd20,8'h5A,16'h0000,0, 0,9'h15A,16'h0004,0, 1,all_5a);
        add("bcast_ackall",0,1,1,5'd0, 8'hA5,16'hFFFF,0,15,9'h1A5,16'h0004,0, 0,'0);
        add("reset_wr",    1,1,0,5'd0, 8'h33,16'h0000,0, 0,9'h000,16'h0000,0, 1,'0);

        // reset and idle inputs
        reset = 1'b1;
        drive_a(1'b0, 1'b0, 5'd0, 8'h00, 16'h0000, 1'b0);
        drive_t(1'b0, 4'd0, 8'h00, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        check("reset_bus",     bus_a.out_bus, '0);
        check("reset_overrun", BW'(bus_a.overrun), '0);
        check("reset_addr_err",BW'(bus_a.addr_err), '0);

        // first write: only channel 3 becomes {1,C0}
        drive_a(1'b1, 1'b0, 5'd3, 8'hC0, 16'h0000, 1'b0);
        tick();
        check("wr3_bus", bus_a.out_bus, place(3, 9'h1C0));
        check("wr3_overrun", BW'(bus_a.overrun), '0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive_a(vecs[i].en, vecs[i].bc, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].clr);
            tick();
            check({vecs[i].name, "_ch"},  BW'(get_ch(bus_a.out_bus, vecs[i].ch)), BW'(vecs[i].exp_ch));
            check({vecs[i].name, "_ovr"}, BW'(bus_a.overrun), BW'(vecs[i].exp_ovr));
            check({vecs[i].name, "_err"}, BW'(bus_a.addr_err), BW'(vecs[i].exp_err));
            if (vecs[i].full) check({vecs[i].name, "_bus"}, bus_a.out_bus, vecs[i].exp_bus);
        end
        reset = 1'b0;
        drive_a(1'b0, 1'b0, 5'd0, 8'h00, 16'h0000, 1'b0);

        // timer instance: write, hold exactly 3 cycles, then expire without overrun
        tick();
        check("tmr_reset_bus", bus_t.out_bus, '0);
        t_step("tmr_wr",   1'b1, 4'd0, 8'h0F, 16'h0, 0, 9'h10F);
        t_step("tmr_c1",   1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h10F);
        t_step("tmr_c2",   1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h10F);
        t_step("tmr_exp",  1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h00F);
        t_step("tmr_stay", 1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h00F);
        check("tmr_exp_no_ovr", BW'(bus_t.overrun), '0);

        // rewrite two cycles in: valid extends 3 cycles from the rewrite, overrun set
        t_step("rw_wr",    1'b1, 4'd0, 8'h0F, 16'h0, 0, 9'h10F);
        t_step("rw_c1",    1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h10F);
        t_step("rw_again", 1'b1, 4'd0, 8'hF1, 16'h0, 0, 9'h1F1);
        t_step("rw_c3",    1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h1F1);
        t_step("rw_c4",    1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h1F1);
        t_step("rw_exp",   1'b0, 4'd0, 8'h00, 16'h0, 0, 9'h0F1);
        check("rw_overrun", BW'(bus_t.overrun), BW'(16'h0001));

        // early ack on channel 5 clears valid and it stays clear
        t_step("ea_wr",    1'b1, 4'd5, 8'h3C, 16'h0000, 5, 9'h13C);
        t_step("ea_ack",   1'b0, 4'd0, 8'h00, 16'h0020, 5, 9'h03C);
        t_step("ea_i1",    1'b0, 4'd0, 8'h00, 16'h0000, 5, 9'h03C);
        t_step("ea_i2",    1'b0, 4'd0, 8'h00, 16'h0000, 5, 9'h03C);
        t_step("ea_i3",    1'b0, 4'd0, 8'h00, 16'h0000, 5, 9'h03C);
        check("ea_overrun", BW'(bus_t.overrun), BW'(16'h0001));

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
